predelay_line: RTL and testbench

Pre-delay stage between the audio controller's left-channel Avalon-ST source and the reverb core input. Each accepted 24-bit sample is written into a circular buffer, and the sample written `predelay_value` samples earlier is emitted. The delay comes from the pre-delay PIO word, in samples. A zeroing sweep clears the buffer after reset and on request.

---
 rtl/predelay_pkg.sv | 15 +
 rtl/predelay_ram.sv | 31 +++
 rtl/predelay_line.sv | 228 ++++++++++++++++++++++
 tb/tb_predelay_line.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/predelay_pkg.sv
// Shared defaults and FSM state encoding for the pre-delay line.
package predelay_pkg;

  localparam int unsigned PD_DATA_W  = 24;
  localparam int unsigned PD_ADDR_W  = 12;
  localparam int unsigned PD_PARAM_W = 24;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_READ  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/predelay_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
// Read-during-write to the same address returns the old word; the caller bypasses.
module predelay_ram
  import predelay_pkg::*;
#(
  parameter int unsigned DATA_W = PD_DATA_W,
  parameter int unsigned ADDR_W = PD_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/predelay_line.sv
// Pre-delay line: each accepted sample is written to a circular buffer and the
// sample d positions older is emitted. `PREDELAY_CLEAR_SWEEP_EN selects a zeroing
// sweep; without it a fill counter masks not-yet-written history.
module predelay_line
  import predelay_pkg::*;
#(
  parameter int unsigned DATA_W  = PD_DATA_W,
  parameter int unsigned ADDR_W  = PD_ADDR_W,
  parameter int unsigned PARAM_W = PD_PARAM_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [PARAM_W-1:0] predelay_value,
  input  logic               clear,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy
);

  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned FILL_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0]  A_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [PARAM_W-1:0] P_LAST = PARAM_W'(DEPTH - 1);

`ifdef PREDELAY_CLEAR_SWEEP_EN
  localparam state_e ST_RST  = ST_CLEAR;
  localparam logic   RDY_RST = 1'b0;
`else
  localparam state_e ST_RST  = ST_IDLE;
  localparam logic   RDY_RST = 1'b1;
`endif

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q;
  logic [ADDR_W-1:0]   d_c;
  logic [ADDR_W-1:0]   rd_addr_c;
  logic [ADDR_W-1:0]   waddr_c;
  logic [DATA_W-1:0]   wdata_c;
  logic [DATA_W-1:0]   ram_q;
  logic [DATA_W-1:0]   lat_data_q;
  logic [DATA_W-1:0]   out_data_q;
  logic [DATA_W-1:0]   out_next_c;
  logic                we_c;
  logic                accept_c;
  logic                service_c;
  logic                clear_pend_q, clear_pend_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q;
  logic                lat_bypass_q;

  // Requested delay clamped to the deepest reachable history entry.
  assign d_c = (predelay_value > P_LAST) ? A_LAST : predelay_value[ADDR_W-1:0];

  assign rd_addr_c = wr_ptr_q - d_c;

`ifdef PREDELAY_CLEAR_SWEEP_EN
  logic [ADDR_W-1:0] clr_addr_q;
  logic              busy_q;
`else
  logic [FILL_W-1:0] fill_q;
  logic              lat_mask_q;
`endif

  // Next-state logic; accept takes priority because in_ready was already shown.
  always_comb begin
    state_d   = state_q;
    accept_c  = 1'b0;
    service_c = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
`ifdef PREDELAY_CLEAR_SWEEP_EN
        if (clr_addr_q == A_LAST) begin
          state_d = ST_IDLE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_IDLE: begin
        if (in_ready_q && in_valid) begin
          accept_c = 1'b1;
          state_d  = ST_READ;
        end else if (clear_pend_q) begin
          service_c = 1'b1;
`ifdef PREDELAY_CLEAR_SWEEP_EN
          state_d = ST_CLEAR;
`endif
        end
      end
      ST_READ: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A clear arriving mid-sweep or while already pending is absorbed.
  always_comb begin
    clear_pend_d = clear_pend_q;
    if (service_c) begin
      clear_pend_d = 1'b0;
    end else if (clear && (state_q != ST_CLEAR)) begin
      clear_pend_d = 1'b1;
    end
    in_ready_d = (state_d == ST_IDLE) && !clear_pend_d;
  end

  // RAM write port: sweep zeros or accepted sample.
  always_comb begin
    we_c    = accept_c;
    waddr_c = wr_ptr_q;
    wdata_c = in_data;
`ifdef PREDELAY_CLEAR_SWEEP_EN
    if (state_q == ST_CLEAR) begin
      we_c    = 1'b1;
      waddr_c = clr_addr_q;
      wdata_c = '0;
    end
`endif
  end

  // Output word: bypass on d=0 collision, masked while history is unwritten.
  always_comb begin
    out_next_c = lat_bypass_q ? lat_data_q : ram_q;
`ifndef PREDELAY_CLEAR_SWEEP_EN
    if (lat_mask_q) begin
      out_next_c = '0;
    end
`endif
  end

  predelay_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (we_c),
    .waddr (waddr_c),
    .wdata (wdata_c),
    .re    (accept_c),
    .raddr (rd_addr_c),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_RST;
      wr_ptr_q     <= '0;
      clear_pend_q <= 1'b0;
      in_ready_q   <= RDY_RST;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      lat_data_q   <= '0;
      lat_bypass_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clear_pend_q <= clear_pend_d;
      in_ready_q   <= in_ready_d;
      if (accept_c) begin
        wr_ptr_q     <= wr_ptr_q + ADDR_W'(1);
        lat_data_q   <= in_data;
        lat_bypass_q <= (d_c == '0);
      end else if (service_c) begin
        wr_ptr_q <= '0;
      end
      if (state_q == ST_READ) begin
        out_valid_q <= 1'b1;
        out_data_q  <= out_next_c;
      end else if ((state_q == ST_HOLD) && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef PREDELAY_CLEAR_SWEEP_EN
  // Sweep address and busy flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_addr_q <= '0;
      busy_q     <= 1'b1;
    end else begin
      busy_q <= (state_d == ST_CLEAR);
      if (state_q == ST_CLEAR) begin
        clr_addr_q <= clr_addr_q + ADDR_W'(1);
      end else if (service_c) begin
        clr_addr_q <= '0;
      end
    end
  end

  assign busy = busy_q;
`else
  // Saturating count of samples written since reset or clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_q     <= '0;
      lat_mask_q <= 1'b0;
    end else begin
      if (accept_c) begin
        lat_mask_q <= (fill_q < FILL_W'(d_c));
        if (fill_q != FILL_W'(DEPTH)) begin
          fill_q <= fill_q + FILL_W'(1);
        end
      end else if (service_c) begin
        fill_q <= '0;
      end
    end
  end

  assign busy = 1'b0;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_predelay_line.sv
// Bench for predelay_line: vector table plus scoreboarded streams and corner sequences.
module tb_predelay_line;

  localparam int unsigned DW = 24;
  localparam int unsigned AW = 12;
  localparam int unsigned PW = 24;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic [PW-1:0] predelay_value;
  logic [DW-1:0] in_data;
  logic [DW-1:0] out_data;

  predelay_line #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .PARAM_W (PW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .predelay_value (predelay_value),
    .clear          (clear),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          do_clear;
    logic [DW-1:0] din;
    int unsigned   pd;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t          vecs [13];
  logic [DW-1:0] sb [$];
  logic [DW-1:0] hist [8192];
  int            mk;
  int            checks;
  int            errors;
  int            out_cnt;
  int            imp_idx;
  int            bcnt;
  logic          in_fired;
  logic          rnd_ready;
  logic [DW-1:0] held;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out", name);
  endtask

  // Reference history: expected output is the sample d positions back, else zero.
  function automatic logic [DW-1:0] model_exp(input logic [DW-1:0] din, input int unsigned pd);
    int d;
    logic [DW-1:0] e;
    d = (pd > 4095) ? 4095 : int'(pd);
    hist[13'(mk)] = din;
    e = (mk >= d) ? hist[13'(mk - d)] : '0;
    mk++;
    return e;
  endfunction

  // One cycle: note handshakes that fire at the coming edge, then step to the next negedge.
  task automatic tick();
    logic [DW-1:0] e;
    if (in_valid && in_ready) in_fired = 1'b1;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected got %h", out_data);
      end else begin
        e = sb.pop_front();
        check("sb_out_data", 32'(out_data), 32'(e));
      end
      if ((out_data == 24'h7FFFFF) && (imp_idx < 0)) imp_idx = out_cnt;
      out_cnt++;
    end
    @(negedge clk);
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [DW-1:0] din, input int unsigned pd, input logic [DW-1:0] e);
    predelay_value = PW'(pd);
    in_data  = din;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_fired = 1'b0;
      tick();
      if (in_fired) begin
        sb.push_back(e);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    timeout("send");
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      if (sb.size() == 0) begin
        tick();
        return;
      end
      tick();
    end
    timeout("drain");
  endtask

  // Counts busy cycles until the block is accepting again.
  task automatic count_busy(output int cnt);
    cnt = 0;
    for (int i = 0; i < 6000; i++) begin
      if (busy) cnt++;
      else if (in_ready && (i >= 2)) return;
      tick();
    end
    timeout("clear_done");
  endtask

  task automatic clear_buf();
    int c;
    drain();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    count_busy(c);
    mk = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    clear = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    predelay_value = '0;
    out_ready = 1'b1;
    rnd_ready = 1'b0;
    checks = 0;
    errors = 0;
    mk = 0;
    out_cnt = 0;
    imp_idx = -1;

    vecs[0] = '{1'b0, 24'hABCDEF, 0, 24'hABCDEF};
    vecs[1] = '{1'b0, 24'h800000, 0, 24'h800000};
    vecs[2] = '{1'b0, 24'h7FFFFF, 0, 24'h7FFFFF};
    vecs[3] = '{1'b1, 24'd1, 3, 24'd0};
    vecs[4] = '{1'b0, 24'd2, 3, 24'd0};
    vecs[5] = '{1'b0, 24'd3, 3, 24'd0};
    vecs[6] = '{1'b0, 24'd4, 3, 24'd1};
    vecs[7] = '{1'b0, 24'd5, 3, 24'd2};
    vecs[8] = '{1'b0, 24'd6, 3, 24'd3};
    vecs[9] = '{1'b0, 24'd7, 3, 24'd4};
    vecs[10] = '{1'b0, 24'd8, 3, 24'd5};
    vecs[11] = '{1'b0, 24'd9, 3, 24'd6};
    vecs[12] = '{1'b0, 24'd10, 3, 24'd7};

    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
`ifdef PREDELAY_CLEAR_SWEEP_EN
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
`else
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    count_busy(bcnt);

    // d=0 latency: accept at N, out_valid at N+2, in_ready back at N+3.
    predelay_value = '0;
    in_data = 24'h000100;
    in_valid = 1'b1;
    check("lat_n_in_ready", 32'(in_ready), 32'd1);
    held = model_exp(24'h000100, 0);
    @(negedge clk);
    in_valid = 1'b0;
    check("lat_n1_out_valid", 32'(out_valid), 32'd0);
    check("lat_n1_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("lat_n2_out_valid", 32'(out_valid), 32'd1);
    check("lat_n2_out_data", 32'(out_data), 32'h000100);
    check("lat_n2_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("lat_n3_in_ready", 32'(in_ready), 32'd1);
    check("lat_n3_out_valid", 32'(out_valid), 32'd0);

    // Vector table: d=0 bypass values, then the d=3 ramp after a clear.
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].do_clear) clear_buf();
      send(vecs[i].din, vecs[i].pd, vecs[i].exp);
    end
    drain();

    // Backpressure: hold output 10 cycles with a second sample offered.
    clear_buf();
    send(24'h111111, 1, model_exp(24'h111111, 1));
    drain();
    out_ready = 1'b0;
    send(24'h222222, 1, model_exp(24'h222222, 1));
    in_data = 24'h333333;
    in_valid = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_data", 32'(out_data), 32'h111111);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    send(24'h333333, 1, model_exp(24'h333333, 1));
    send(24'h444444, 1, model_exp(24'h444444, 1));
    drain();

    // Clear pulsed during HOLD: pending sample completes, then the clear runs.
    clear_buf();
    send(24'h0A0001, 2, model_exp(24'h0A0001, 2));
    send(24'h0A0002, 2, model_exp(24'h0A0002, 2));
    send(24'h0A0003, 2, model_exp(24'h0A0003, 2));
    drain();
    out_ready = 1'b0;
    send(24'h0A0004, 2, model_exp(24'h0A0004, 2));
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("hold_clr_busy", 32'(busy), 32'd0);
    check("hold_clr_out_valid", 32'(out_valid), 32'd1);
    check("hold_clr_out_data", 32'(out_data), 32'h0A0002);
    out_ready = 1'b1;
    tick();
    mk = 0;
    count_busy(bcnt);
`ifdef PREDELAY_CLEAR_SWEEP_EN
    check("hold_clr_busy_cycles", 32'(bcnt), 32'd4096);
`else
    check("hold_clr_busy_cycles", 32'(bcnt), 32'd0);
`endif
    for (int k = 1; k <= 4; k++) begin
      send(24'h0B0000 + 24'(k), 2, model_exp(24'h0B0000 + 24'(k), 2));
    end
    drain();

    // Clamp: predelay 5000 acts as 4095; impulse emerges 4095 samples later.
    clear_buf();
    out_cnt = 0;
    imp_idx = -1;
    send(24'h7FFFFF, 5000, model_exp(24'h7FFFFF, 5000));
    for (int k = 1; k <= 4096; k++) begin
      send(24'h000000, 5000, model_exp(24'h000000, 5000));
    end
    drain();
    check("clamp_impulse_index", 32'(imp_idx), 32'd4095);

    // Write-pointer wrap with random output backpressure, d=2.
    clear_buf();
    rnd_ready = 1'b1;
    for (int k = 0; k < 4100; k++) begin
      send(24'(k), 2, model_exp(24'(k), 2));
    end
    drain();
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    tick();
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
